uart_receiver_fsm: RTL and testbench

UART_RECEIVER_FSM -- requirements
Module: uart_receiver_fsm

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_receiver_fsm_if.sv | 8 +
 rtl/uart_rx_sampler.sv | 36 +++
 rtl/uart_receiver_fsm.sv | 97 +++++++++
 tb/tb_uart_receiver_fsm.sv | 132 +++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encodings and parity-type constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/uart_receiver_fsm_if.sv
// uart_receiver_fsm_if: serial line, frame options and received-word results
interface uart_receiver_fsm_if #(parameter int DATA_WIDTH = 8);
    logic rx_in, par_en, par_typ;
    logic [DATA_WIDTH-1:0] data_out;
    logic data_valid, par_err, stp_err, busy;
    modport master(output rx_in, par_en, par_typ, input data_out, data_valid, par_err, stp_err, busy);
    modport slave(input rx_in, par_en, par_typ, output data_out, data_valid, par_err, stp_err, busy);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit sample counter with 2-of-3 majority vote around mid-bit
module uart_rx_sampler #(parameter int PRESCALE = 8) (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    input  logic run,
    output logic bit_value,
    output logic vote_strobe,
    output logic bit_end
);
    localparam int CW = $clog2(PRESCALE);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] samp_q, samp_d;
    logic vote_q, vote_d, maj;
    always_comb begin
        maj         = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_in) | (samp_q[1] & rx_in);
        vote_strobe = cnt_q == CW'(PRESCALE / 2 + 1);
        bit_end     = cnt_q == CW'(PRESCALE - 1);
        bit_value   = vote_strobe ? maj : vote_q;
        samp_d[0]   = cnt_q == CW'(PRESCALE / 2 - 1) ? rx_in : samp_q[0];
        samp_d[1]   = cnt_q == CW'(PRESCALE / 2) ? rx_in : samp_q[1];
        vote_d      = bit_value;
    end
    assign cnt_d = (!run || bit_end) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            samp_q <= '0;
            vote_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            samp_q <= samp_d;
            vote_q <= vote_d;
        end
    end
endmodule

// File: rtl/uart_receiver_fsm.sv
// uart_receiver_fsm: oversampled UART receive FSM with optional parity and stop-bit checking
module uart_receiver_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input logic clk,
    input logic reset,
    uart_receiver_fsm_if.slave u
);
    localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d, data_q, data_d;
    logic pen_q, pen_d, ptyp_q, ptyp_d, pbad_q, pbad_d;
    logic dv_q, dv_d, pe_q, pe_d, se_q, se_d;
    logic bit_value, vote_strobe, bit_end;
    uart_rx_sampler #(.PRESCALE(PRESCALE)) sampler (
        .clk(clk),
        .reset(reset),
        .rx_in(u.rx_in),
        .run(state_d != IDLE),
        .bit_value(bit_value),
        .vote_strobe(vote_strobe),
        .bit_end(bit_end)
    );
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        data_d  = data_q;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
        pbad_d  = pbad_q;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        se_d    = 1'b0;
        case (state_q)
            IDLE: if (!u.rx_in) begin
                state_d = START;
                pen_d   = u.par_en;
                ptyp_d  = u.par_typ;
                pbad_d  = 1'b0;
                idx_d   = '0;
            end
            START: if (bit_end) state_d = bit_value ? IDLE : DATA;
            DATA: if (bit_end) begin
                sr_d[idx_q] = bit_value;
                idx_d       = idx_q + 1'b1;
                if (idx_q == IW'(DATA_WIDTH - 1)) state_d = pen_q ? PARITY : STOP;
            end
            PARITY: if (bit_end) begin
                pbad_d  = bit_value != (^sr_q ^ (ptyp_q == PAR_ODD));
                state_d = STOP;
            end
            STOP: if (vote_strobe) begin
                state_d = IDLE;
                dv_d    = bit_value & ~pbad_q;
                pe_d    = pbad_q;
                se_d    = ~bit_value;
                data_d  = dv_d ? sr_q : data_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            pbad_q  <= 1'b0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
            pbad_q  <= pbad_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end
    assign u.data_out   = data_q;
    assign u.data_valid = dv_q;
    assign u.par_err    = pe_q;
    assign u.stp_err    = se_q;
    assign u.busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_receiver_fsm.sv
// tb_uart_receiver_fsm: scoreboard bench for framing, parity, stop errors, glitches and reset
module tb_uart_receiver_fsm;
    import uart_pkg::*;
    localparam int DW = 8;
    localparam int P  = 8;
    localparam int T  = 10;
    typedef struct {
        longint t;
        logic dv, pe, se;
        logic [DW-1:0] d;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    logic [DW-1:0] last_good = '0;
    always #5 clk = ~clk;
    uart_receiver_fsm_if #(.DATA_WIDTH(DW)) u ();
    uart_receiver_fsm #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
        .clk(clk),
        .reset(reset),
        .u(u.slave)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic drive_bit(input logic b, input int n);
        u.rx_in = b;
        repeat (n) @(negedge clk);
    endtask
    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                              input logic flip, input logic stop);
        exp_t e;
        e.t  = longint'($time) + longint'(T * ((1 + DW + int'(pen)) * P + P / 2 + 2));
        e.pe = pen & flip;
        e.se = ~stop;
        e.dv = stop & ~e.pe;
        if (e.dv) last_good = d;
        e.d = last_good;
        sb.push_back(e);
        u.par_en  = pen;
        u.par_typ = ptyp;
        drive_bit(1'b0, 1);
        u.par_en  = ~pen;
        u.par_typ = ~ptyp;
        drive_bit(1'b0, P - 1);
        for (int i = 0; i < DW; i++) drive_bit(d[i], P);
        if (pen) drive_bit(^d ^ ptyp ^ flip, P);
        if (stop) drive_bit(1'b1, P);
        else begin
            drive_bit(1'b0, P / 2 + 2);
            drive_bit(1'b1, P / 2 - 2);
        end
    endtask
    always @(negedge clk) begin : monitor
        exp_t e;
        if (u.data_valid === 1'b1 || u.par_err === 1'b1 || u.stp_err === 1'b1) begin
            if (sb.size() == 0) check("unexpected_pulse", {u.data_valid, u.par_err, u.stp_err}, 64'd0);
            else begin
                e = sb.pop_front();
                check("pulse_time", $time, e.t);
                check("data_valid", u.data_valid, e.dv);
                check("par_err", u.par_err, e.pe);
                check("stp_err", u.stp_err, e.se);
                check("data_out", u.data_out, e.d);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
    initial begin
        logic [DW-1:0] rd;
        u.rx_in = 1'b1;
        u.par_en = 1'b0;
        u.par_typ = PAR_EVEN;
        repeat (3) @(negedge clk);
        check("rst_data_out", u.data_out, 0);
        check("rst_data_valid", u.data_valid, 0);
        check("rst_par_err", u.par_err, 0);
        check("rst_stp_err", u.stp_err, 0);
        check("rst_busy", u.busy, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, PAR_EVEN, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, PAR_EVEN, 1'b1, 1'b1);
        send_frame(8'h81, 1'b0, PAR_EVEN, 1'b0, 1'b0);
        check("stop_err_idle", u.busy, 0);
        repeat (4) @(negedge clk);
        u.rx_in = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("glitch_busy", u.busy, c < 8);
            if (c == 2) u.rx_in = 1'b1;
        end
        repeat (4) @(negedge clk);
        send_frame(8'h12, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        send_frame(8'h34, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        rd = 8'hF0;
        drive_bit(1'b0, P);
        for (int i = 0; i < 4; i++) drive_bit(rd[i], P);
        drive_bit(rd[4], 3);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_data_out", u.data_out, 0);
        check("midrst_data_valid", u.data_valid, 0);
        check("midrst_par_err", u.par_err, 0);
        check("midrst_stp_err", u.stp_err, 0);
        check("midrst_busy", u.busy, 0);
        reset = 1'b0;
        u.rx_in = 1'b1;
        last_good = '0;
        repeat (3) @(negedge clk);
        send_frame(8'h55, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b1, PAR_ODD, 1'b0, 1'b1);
        send_frame(8'h5B, 1'b1, PAR_ODD, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++)
            send_frame(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
